socket_writer: RTL and testbench
================================

Name: socket_writer

Overview:
- Producer-side socket controller: takes a sample stream from an upstream task and writes it into the socket FIFO.
- Issues o_wr_en whenever data is held and the FIFO is not full.
- Transfers in frames of FRAME_LEN samples; each frame is started by i_start.
- Counterpart of the consumer-side read controller on the same FIFO.

Parameters:
- DATA_W, 8, sample width in bits.
- FRAME_LEN, 4, samples per frame (>=1).
- FCNT_W, 16, width of frame counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  start one frame; sampled only in st_idle.
- i_data  input  DATA_W  upstream sample.
- i_valid  input  1  upstream sample valid.
- o_ready  output  1  sample accepted when i_valid & o_ready.
- i_full  input  1  FIFO full flag.
- o_wr_en  output  1  FIFO write strobe.
- o_wr_data  output  DATA_W  FIFO write data.
- o_busy  output  1  high in st_run or st_drain.
- o_frame_done  output  1  one-cycle pulse, frame fully written.
- o_frame_cnt  output  FCNT_W  completed frames, wraps.

Behaviour:
- Reset is i_rst, asynchronous, active-high; clock is i_clk. On reset:
  - state=st_idle, hold_valid=0, hold_data=0, sample count=0, o_frame_cnt=0.
  - Outputs o_ready=0, o_wr_en=0, o_wr_data=0, o_busy=0, o_frame_done=0.
- Hold register: one entry (hold_valid, hold_data).
  - o_wr_en = hold_valid & ~i_full (combinational).
  - o_wr_data = hold_data.
- Acceptance: o_ready = (state==st_run) & (~hold_valid | ~i_full).
  - On accept, hold_data <= i_data and hold_valid <= 1, in the same cycle as any write of the old entry.
  - Accepting and writing in the same cycle allows one sample per cycle when not full.
  - Write without accept: hold_valid <= 0.
- Latency: a sample accepted in cycle N appears on o_wr_en/o_wr_data in cycle N+1 if i_full=0. While i_full=1 it waits in the hold register, and data is held stable.
- Sample counter, width $clog2(FRAME_LEN+1): increments on each accept in st_run.
- FSM states:
  - st_idle: o_ready=0. If i_start, clear sample counter and go to st_run.
  - st_run: accept samples. On the accept that makes count==FRAME_LEN, go to st_drain in the next cycle; no further accepts.
  - st_drain: o_ready=0. When o_wr_en=1 and hold_valid (the last sample is written): o_frame_done=1 that cycle, o_frame_cnt+1, go to st_idle.
- Timing of o_frame_done: combinational, asserted in the cycle of the final write (registered variant forbidden).
- Boundary conditions:
  - FRAME_LEN=1: st_idle -> st_run -> one accept -> st_drain.
  - i_full held high in st_drain: stay in st_drain indefinitely; o_frame_done is not asserted.
  - i_start while busy: ignored.
  - i_start in the same cycle a frame completes: ignored; a new i_start is needed in st_idle.
  - i_valid low in st_run: no count change, no timeout.
  - Frame counter wraps 2^FCNT_W-1 -> 0.
  - Reset mid-frame: partial frame and held sample discarded; no write occurs after reset assertion.
- No write ever occurs while i_full=1. A held sample is never lost or duplicated.

Decomposition:
- Shared package socket_pkg:
  - t_wr_state enum {st_idle, st_run, st_drain}, alongside the existing read-side state enum.
- Sub-module socket_hold_reg: one-entry register slice with in_valid/in_ready/out_valid/out_ready and data.
  - socket_writer instantiates it, gating in_valid with st_run and out_ready with ~i_full.

Test Plan:
- Reset then i_start, i_valid=1, i_data=0x10..0x13, i_full=0 -> o_wr_en high cycles 2-5 with data 0x10,0x11,0x12,0x13; o_frame_done pulse with 0x13; o_frame_cnt=1; o_ready=0 after 4th accept.
- Same frame, i_full=1 for 3 cycles after the 2nd write -> o_wr_en=0 and o_wr_data=0x12 stable; o_ready=0 while hold full; resumes 0x12,0x13; exactly 4 writes total.
- i_full=1 throughout st_drain for 10 cycles -> state stays st_drain, no o_frame_done; release -> single write 0x13 and pulse.
- i_start pulsed mid-frame and at completion cycle -> ignored; o_frame_cnt increments by 1 only; next frame needs a fresh i_start.
- i_rst asserted after 2 accepts, hold_valid=1 -> o_wr_en=0 immediately; o_busy=0, o_frame_cnt=0; next frame writes exactly 4 new samples.
- FCNT_W=2, 5 back-to-back frames -> o_frame_cnt 1,2,3,0,1.

Source files
------------

// File: rtl/socket_pkg.sv
// Shared types for the socket FIFO controllers on both sides of the same FIFO.
// Write side uses t_wr_state. Read side uses t_rd_state.
package socket_pkg;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_run   = 2'd1,
    st_drain = 2'd2
  } t_wr_state;

  typedef enum logic [1:0] {
    st_rd_idle  = 2'd0,
    st_rd_fetch = 2'd1,
    st_rd_drain = 2'd2
  } t_rd_state;

endpackage

// File: rtl/socket_hold_reg.sv
// One-entry register slice. It can load a new sample and hand out the old one
// in the same cycle, so it sustains one sample per cycle while the sink is ready.
module socket_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;

  assign in_ready  = ~hold_valid | out_ready;
  assign out_valid = hold_valid;
  assign out_data  = hold_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (in_valid && in_ready) begin
      hold_valid <= 1'b1;
      hold_data  <= in_data;
    end else if (hold_valid && out_ready) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/socket_writer.sv
// Producer-side socket controller. It accepts FRAME_LEN samples per i_start
// and writes them into the socket FIFO through a one-entry hold register.
//
// state    | meaning
// st_idle  | waiting for i_start, nothing accepted
// st_run   | accepting samples until FRAME_LEN have been taken
// st_drain | last sample held, waiting for the FIFO to take it
module socket_writer
  import socket_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int FCNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_full,
  output logic              o_wr_en,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [FCNT_W-1:0] o_frame_cnt
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  t_wr_state         state, state_nxt;
  logic [CNT_W-1:0]  sample_cnt, sample_cnt_nxt;
  logic [FCNT_W-1:0] frame_cnt_nxt;
  logic              in_run;
  logic              hold_in_ready;
  logic              hold_valid;
  logic              accept;

  assign in_run  = (state == st_run);
  assign o_ready = in_run & hold_in_ready;
  assign accept  = i_valid & o_ready;
  assign o_wr_en = hold_valid & ~i_full;
  assign o_busy  = (state == st_run) | (state == st_drain);

  socket_hold_reg #(
    .DATA_W(DATA_W)
  ) u_hold (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .in_valid (i_valid & in_run),
    .in_ready (hold_in_ready),
    .in_data  (i_data),
    .out_valid(hold_valid),
    .out_ready(~i_full),
    .out_data (o_wr_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= st_idle;
      sample_cnt  <= '0;
      o_frame_cnt <= '0;
    end else begin
      state       <= state_nxt;
      sample_cnt  <= sample_cnt_nxt;
      o_frame_cnt <= frame_cnt_nxt;
    end
  end

  // Frame completion is combinational so the pulse lines up with the final write.
  always_comb begin
    state_nxt      = state;
    sample_cnt_nxt = sample_cnt;
    frame_cnt_nxt  = o_frame_cnt;
    o_frame_done   = 1'b0;
    case (state)
      st_idle: begin
        if (i_start) begin
          sample_cnt_nxt = '0;
          state_nxt      = st_run;
        end
      end
      st_run: begin
        if (accept) begin
          sample_cnt_nxt = sample_cnt + CNT_W'(1);
          if (sample_cnt == LAST_IDX) state_nxt = st_drain;
        end
      end
      st_drain: begin
        if (o_wr_en) begin
          o_frame_done  = 1'b1;
          frame_cnt_nxt = o_frame_cnt + FCNT_W'(1);
          state_nxt     = st_idle;
        end
      end
      default: state_nxt = st_idle;
    endcase
  end

endmodule

// File: tb/tb_socket_writer.sv
// Directed bench for socket_writer: frame flow, FIFO backpressure, drain stall,
// ignored starts, mid-frame reset and frame-counter wrap on a narrow instance.
module tb_socket_writer;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       rst2  = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_full = 1'b0;

  logic        o_ready, o_wr_en, o_busy, o_frame_done;
  logic [7:0]  o_wr_data;
  logic [15:0] o_frame_cnt;

  logic        ready2, wr_en2, busy2, done2;
  logic [7:0]  wr_data2;
  logic [1:0]  frame_cnt2;

  int total = 0;
  int bad   = 0;
  int wr_count = 0;

  always #5 i_clk = ~i_clk;

  socket_writer #(.DATA_W(8), .FRAME_LEN(4), .FCNT_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_data(i_data),
    .i_valid(i_valid), .o_ready(o_ready), .i_full(i_full), .o_wr_en(o_wr_en),
    .o_wr_data(o_wr_data), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_frame_cnt(o_frame_cnt)
  );

  socket_writer #(.DATA_W(8), .FRAME_LEN(4), .FCNT_W(2)) dut2 (
    .i_clk(i_clk), .i_rst(rst2), .i_start(i_start), .i_data(i_data),
    .i_valid(i_valid), .o_ready(ready2), .i_full(i_full), .o_wr_en(wr_en2),
    .o_wr_data(wr_data2), .o_busy(busy2), .o_frame_done(done2),
    .o_frame_cnt(frame_cnt2)
  );

  always @(posedge i_clk) if (!i_rst && o_wr_en) wr_count++;

  always @(negedge i_clk) begin
    total++;
    assert (!(o_wr_en && i_full)) else begin
      bad++;
      $error("FAIL wr_while_full observed=%0b expected=0", o_wr_en);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic run_frame(input logic [7:0] base);
    i_start = 1'b1; i_valid = 1'b1; i_data = base;
    tick();
    i_start = 1'b0;
    tick();
    for (int i = 1; i < 4; i++) begin
      i_data = base + 8'(i);
      settle();
      chk("rf_wr_en", 32'(o_wr_en), 32'd1);
      chk("rf_wr_data", 32'(o_wr_data), 32'(base + 8'(i - 1)));
      tick();
    end
    i_valid = 1'b0;
    settle();
    chk("rf_done", 32'(o_frame_done), 32'd1);
    chk("rf_last", 32'(o_wr_data), 32'(base + 8'd3));
    tick();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_wr_en", 32'(o_wr_en), 32'd0);
    chk("rst_wr_data", 32'(o_wr_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_frame_done), 32'd0);
    chk("rst_cnt", 32'(o_frame_cnt), 32'd0);
    i_rst = 1'b0;
    tick();

    // Frame 1: clean stream 0x10..0x13
    wr_count = 0;
    i_start = 1'b1; i_valid = 1'b1; i_data = 8'h10;
    settle();
    chk("t1_idle_ready", 32'(o_ready), 32'd0);
    tick();
    i_start = 1'b0;
    settle();
    chk("t1_run_ready", 32'(o_ready), 32'd1);
    chk("t1_run_busy", 32'(o_busy), 32'd1);
    chk("t1_no_wr_yet", 32'(o_wr_en), 32'd0);
    tick();
    i_data = 8'h11; settle();
    chk("t1_wr0_en", 32'(o_wr_en), 32'd1);
    chk("t1_wr0", 32'(o_wr_data), 32'h10);
    tick();
    i_data = 8'h12; settle();
    chk("t1_wr1", 32'(o_wr_data), 32'h11);
    tick();
    i_data = 8'h13; settle();
    chk("t1_wr2", 32'(o_wr_data), 32'h12);
    chk("t1_ready4", 32'(o_ready), 32'd1);
    tick();
    i_data = 8'h14; settle();
    chk("t1_drain_ready", 32'(o_ready), 32'd0);
    chk("t1_wr3_en", 32'(o_wr_en), 32'd1);
    chk("t1_wr3", 32'(o_wr_data), 32'h13);
    chk("t1_done", 32'(o_frame_done), 32'd1);
    tick();
    i_valid = 1'b0; settle();
    chk("t1_idle_busy", 32'(o_busy), 32'd0);
    chk("t1_idle_done", 32'(o_frame_done), 32'd0);
    chk("t1_cnt", 32'(o_frame_cnt), 32'd1);
    chk("t1_writes", 32'(wr_count), 32'd4);

    // Frame 2: FIFO full for 3 cycles after the 2nd write
    wr_count = 0;
    i_start = 1'b1; i_valid = 1'b1; i_data = 8'h10;
    tick();
    i_start = 1'b0;
    tick();
    i_data = 8'h11;
    tick();
    i_data = 8'h12;
    tick();
    i_full = 1'b1; i_data = 8'h13;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t2_full_wr_en", 32'(o_wr_en), 32'd0);
      chk("t2_full_data", 32'(o_wr_data), 32'h12);
      chk("t2_full_ready", 32'(o_ready), 32'd0);
      tick();
    end
    i_full = 1'b0; settle();
    chk("t2_resume_en", 32'(o_wr_en), 32'd1);
    chk("t2_resume_data", 32'(o_wr_data), 32'h12);
    chk("t2_resume_ready", 32'(o_ready), 32'd1);
    tick();
    i_valid = 1'b0; settle();
    chk("t2_last", 32'(o_wr_data), 32'h13);
    chk("t2_done", 32'(o_frame_done), 32'd1);
    tick();
    chk("t2_cnt", 32'(o_frame_cnt), 32'd2);
    chk("t2_writes", 32'(wr_count), 32'd4);

    // Frame 3: FIFO full throughout drain
    wr_count = 0;
    i_start = 1'b1; i_valid = 1'b1; i_data = 8'h10;
    tick();
    i_start = 1'b0;
    tick();
    i_data = 8'h11; tick();
    i_data = 8'h12; tick();
    i_data = 8'h13; tick();
    i_valid = 1'b0; i_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("t3_stall_busy", 32'(o_busy), 32'd1);
      chk("t3_stall_done", 32'(o_frame_done), 32'd0);
      chk("t3_stall_wr", 32'(o_wr_en), 32'd0);
      tick();
    end
    i_full = 1'b0; settle();
    chk("t3_rel_wr", 32'(o_wr_en), 32'd1);
    chk("t3_rel_data", 32'(o_wr_data), 32'h13);
    chk("t3_rel_done", 32'(o_frame_done), 32'd1);
    tick();
    chk("t3_busy", 32'(o_busy), 32'd0);
    chk("t3_cnt", 32'(o_frame_cnt), 32'd3);
    chk("t3_writes", 32'(wr_count), 32'd4);

    // Frame 4: i_start pulses mid-frame and at completion are ignored
    i_start = 1'b1; i_valid = 1'b1; i_data = 8'h30;
    tick();
    i_start = 1'b0; tick();
    i_data = 8'h31; i_start = 1'b1; tick();
    i_data = 8'h32; i_start = 1'b0; tick();
    i_data = 8'h33; tick();
    i_valid = 1'b0; i_start = 1'b1; settle();
    chk("t4_done", 32'(o_frame_done), 32'd1);
    tick();
    i_start = 1'b0; settle();
    chk("t4_busy", 32'(o_busy), 32'd0);
    chk("t4_cnt", 32'(o_frame_cnt), 32'd4);
    tick();
    chk("t4_still_idle", 32'(o_busy), 32'd0);
    chk("t4_cnt_hold", 32'(o_frame_cnt), 32'd4);

    // Reset mid-frame after two accepts
    wr_count = 0;
    i_start = 1'b1; i_valid = 1'b1; i_data = 8'h40;
    tick();
    i_start = 1'b0; tick();
    i_data = 8'h41; tick();
    i_rst = 1'b1; i_valid = 1'b0; settle();
    chk("t5_rst_wr_en", 32'(o_wr_en), 32'd0);
    chk("t5_rst_busy", 32'(o_busy), 32'd0);
    chk("t5_rst_cnt", 32'(o_frame_cnt), 32'd0);
    tick();
    chk("t5_writes_pre", 32'(wr_count), 32'd1);
    i_rst = 1'b0; tick();
    chk("t5_idle_wr_en", 32'(o_wr_en), 32'd0);
    wr_count = 0;
    run_frame(8'h20);
    chk("t5_cnt", 32'(o_frame_cnt), 32'd1);
    chk("t5_writes", 32'(wr_count), 32'd4);

    // FCNT_W=2 instance: five back-to-back frames wrap the counter
    rst2 = 1'b0;
    tick();
    chk("t6_cnt0", 32'(frame_cnt2), 32'd0);
    run_frame(8'h50);
    chk("t6_cnt1", 32'(frame_cnt2), 32'd1);
    run_frame(8'h60);
    chk("t6_cnt2", 32'(frame_cnt2), 32'd2);
    run_frame(8'h70);
    chk("t6_cnt3", 32'(frame_cnt2), 32'd3);
    run_frame(8'h80);
    chk("t6_cnt_wrap", 32'(frame_cnt2), 32'd0);
    run_frame(8'h90);
    chk("t6_cnt_after", 32'(frame_cnt2), 32'd1);
    chk("t6_busy2", 32'(busy2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
